ads1115_scan_monitor: RTL and testbench
=======================================

Name: ads1115_scan_monitor

Overview:
- Multi-channel successor to the single-channel A0 threshold indicator.
- Round-robin sequencer: requests one conversion per channel from the I2C read engine, classifies each 16-bit result into FAULT/NORMAL/HIGH with hysteresis and debounce, and stores the latest sample per channel.
- Drives active-low zone LEDs for one operator-selected channel.
- Sits between the ADS1115 I2C master and board LEDs/switches.

Parameters:
- NUM_CH, 4, channels scanned (1..4, ADS1115 AIN0..AIN3).
- DATA_W, 16, conversion width.
- TH_LOW, 16'h0FA0, below this = FAULT.
- TH_HIGH, 16'h57E4, above this = HIGH.
- TH_FAULT, 16'h7D00, above this = FAULT.
- HYST, 16'h0080, HIGH->NORMAL release margin.
- DEBOUNCE, 3, consecutive agreeing samples before committing a zone change (>=1).
- SCAN_GAP, 1000, idle clk cycles between conversions.
- TIMEOUT, 100000, max clk cycles waiting for a conversion.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sel  in  $clog2(NUM_CH) (min 1)  channel shown on LEDs.
- conv_req  out  1  one-cycle request pulse to the I2C engine.
- conv_ch  out  2  channel for conv_req, held stable until the result or timeout.
- conv_valid  in  1  one-cycle result strobe.
- conv_data  in  DATA_W  result, valid with conv_valid.
- zone  out  2*NUM_CH  per-channel committed zone: 00 FAULT, 01 NORMAL, 10 HIGH, 11 UNKNOWN.
- samples  out  NUM_CH*DATA_W  latest raw result per channel.
- timeout_err  out  NUM_CH  sticky per-channel timeout flag (feature-dependent).
- led_n  out  3  active-low [0] FAULT, [1] NORMAL, [2] HIGH for channel sel.

Behaviour:
- Reset (async):
  - FSM enters GAP with gap counter 0 and channel index 0.
  - zone = all 11; samples = 0; debounce counters = 0; timeout_err = 0.
  - conv_req = 0; conv_ch = 0; led_n = 3'b111.
- FSM:
  - GAP: count SCAN_GAP cycles, then go to REQ.
  - REQ: assert conv_req for exactly 1 cycle with conv_ch = index, then go to WAIT.
  - WAIT: on conv_valid, latch conv_data into samples[index] and go to EVAL.
  - EVAL: update the classifier for this channel, advance index (NUM_CH-1 wraps to 0), go to GAP.
  - Latency: conv_valid -> zone update visible 2 cycles later (latch, then EVAL register).
- conv_valid outside WAIT is ignored; samples and zone are unchanged.
- Classification: unsigned compare, so negative two's-complement readings fall into FAULT. Candidate zone:
  - FAULT if data < TH_LOW or data > TH_FAULT.
  - Else HIGH if data > TH_HIGH.
  - Else, if committed zone is HIGH and data > TH_HIGH-HYST: stay HIGH.
  - Otherwise NORMAL.
- Debounce, per channel:
  - If committed == UNKNOWN: commit the candidate immediately and clear the counter.
  - Else if candidate == committed: clear the counter.
  - Else if the candidate differs from the previously pending candidate: counter = 1 and store the new pending candidate.
  - Else increment the counter; when it reaches DEBOUNCE, commit and clear.
  - DEBOUNCE=1: commit on the first differing sample.
- LEDs: registered, 1-cycle delay from zone/sel.
  - Exactly one bit low per committed zone; all high for UNKNOWN.
  - sel >= NUM_CH also gives all high.
- sel may change at any time; this has no effect on scanning.
- Reset mid-WAIT: the pending result is discarded and the scan restarts at channel 0.

Optional Feature:
- ADS_SCAN_TIMEOUT_EN defined:
  - WAIT counts cycles; on reaching TIMEOUT without conv_valid, set timeout_err[index], force zone[index] = UNKNOWN, and clear that channel's debounce state.
  - samples[index] is unchanged; the FSM advances to the next channel via GAP.
  - A later valid result on that channel clears nothing; timeout_err is sticky until rst.
- Undefined:
  - WAIT waits indefinitely.
  - timeout_err is tied to 0.
  - The timeout counter is not synthesised.

Test Plan:
- After reset, with the bench answering every conv_req with data 16'h3000 three cycles later: conv_ch sequence is 0,1,2,3,0. Each zone goes 11->01 after that channel's first result. With sel=0, led_n = 3'b101.
- Channel 1 committed NORMAL, results 16'h6000 three times: zone[3:2] stays 01 after samples 1 and 2 and becomes 10 after sample 3. With sel=1, led_n = 3'b011.
- Hysteresis on channel 2 (committed HIGH): results 16'h57A0 x3 keep HIGH (> 16'h5764). Results 16'h5700 x3 commit NORMAL.
- Fault bounds: results 16'h0F9F, 16'h7D01 and 16'h8000 each classify FAULT. 16'h0FA0 and 16'h7D00 classify NORMAL/HIGH respectively. Verify each after DEBOUNCE samples.
- Debounce interruption on channel 0 (NORMAL): samples HIGH, HIGH, NORMAL, HIGH, HIGH leave zone 01. A third consecutive HIGH commits 10.
- With ADS_SCAN_TIMEOUT_EN and TIMEOUT=50: leave channel 3 unanswered. After 50 WAIT cycles, timeout_err = 4'b1000, zone[7:6] = 11, and the next conv_req is for channel 0. Assert rst mid-WAIT: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ads1115_scan_monitor.sv
// Round-robin ADS1115 scan sequencer with per-channel hysteresis/debounce zone classifier and LED view.
// Optional conversion timeout is enabled by defining ADS_SCAN_TIMEOUT_EN.
module ads1115_scan_monitor #(
  parameter int unsigned        NUM_CH   = 4,
  parameter int unsigned        DATA_W   = 16,
  parameter logic [DATA_W-1:0]  TH_LOW   = DATA_W'(16'h0FA0),
  parameter logic [DATA_W-1:0]  TH_HIGH  = DATA_W'(16'h57E4),
  parameter logic [DATA_W-1:0]  TH_FAULT = DATA_W'(16'h7D00),
  parameter logic [DATA_W-1:0]  HYST     = DATA_W'(16'h0080),
  parameter int unsigned        DEBOUNCE = 3,
  parameter int unsigned        SCAN_GAP = 1000,
  parameter int unsigned        TIMEOUT  = 100000,
  localparam int unsigned       SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         sel,
  output logic                     conv_req,
  output logic [1:0]               conv_ch,
  input  logic                     conv_valid,
  input  logic [DATA_W-1:0]        conv_data,
  output logic [2*NUM_CH-1:0]      zone,
  output logic [NUM_CH*DATA_W-1:0] samples,
  output logic [NUM_CH-1:0]        timeout_err,
  output logic [2:0]               led_n
);

  localparam int unsigned GAP_W = $clog2(SCAN_GAP + 1);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [DATA_W-1:0] TH_REL = TH_HIGH - HYST;

  localparam logic [1:0] Z_FAULT   = 2'b00;
  localparam logic [1:0] Z_NORMAL  = 2'b01;
  localparam logic [1:0] Z_HIGH    = 2'b10;
  localparam logic [1:0] Z_UNKNOWN = 2'b11;

  if (NUM_CH < 1 || NUM_CH > 4 || DEBOUNCE < 1 || SCAN_GAP < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("ads1115_scan_monitor: parameter out of range");
  end

  typedef enum logic [1:0] {S_GAP, S_REQ, S_WAIT, S_EVAL} state_t;

  state_t            state, state_next;
  logic [SEL_W-1:0]  idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic              gap_done, last_ch, to_done;
  logic              req_c, latch_c, eval_c, advance_c;

  logic [DATA_W-1:0] sample_q [NUM_CH];
  logic [1:0]        zone_q   [NUM_CH];
  logic [1:0]        pend_q   [NUM_CH];
  logic [DB_W-1:0]   cnt_q    [NUM_CH];

  logic [DATA_W-1:0] cur;
  logic [1:0]        committed, cand, zone_n, pend_n;
  logic [DB_W-1:0]   cnt_n;
  int unsigned       cnt_inc;
  logic [2:0]        led_c;

  assign gap_done = (32'(gap_cnt) == SCAN_GAP - 1);
  assign last_ch  = (32'(idx) == NUM_CH - 1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_GAP;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_GAP:   if (gap_done) state_next = S_REQ;
      S_REQ:   state_next = S_WAIT;
      S_WAIT: begin
        if (conv_valid)   state_next = S_EVAL;
        else if (to_done) state_next = S_GAP;
      end
      S_EVAL:  state_next = S_GAP;
      default: state_next = S_GAP;
    endcase
  end

  // FSM output decode
  always_comb begin
    req_c     = (state_next == S_REQ);
    latch_c   = (state == S_WAIT) && conv_valid;
    eval_c    = (state == S_EVAL);
    advance_c = eval_c || to_done;
  end

`ifdef ADS_SCAN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]   to_cnt;
  logic [NUM_CH-1:0] to_err_q;

  assign to_done     = (state == S_WAIT) && !conv_valid && (32'(to_cnt) == TIMEOUT - 1);
  assign timeout_err = to_err_q;

  // Cycles spent in WAIT and sticky per-channel timeout flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt   <= '0;
      to_err_q <= '0;
    end else begin
      to_cnt <= (state == S_WAIT && !to_done) ? to_cnt + TO_W'(1) : '0;
      if (to_done) to_err_q[idx] <= 1'b1;
    end
  end
`else
  assign to_done     = 1'b0;
  assign timeout_err = '0;
`endif

  // Sequencer counters and registered request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt  <= '0;
      idx      <= '0;
      conv_req <= 1'b0;
    end else begin
      gap_cnt  <= (state == S_GAP && !gap_done) ? gap_cnt + GAP_W'(1) : '0;
      conv_req <= req_c;
      if (advance_c) idx <= last_ch ? '0 : idx + SEL_W'(1);
    end
  end

  assign conv_ch = 2'(idx);

  // Candidate zone with hysteresis, then debounce against the committed zone
  always_comb begin
    cur       = sample_q[idx];
    committed = zone_q[idx];
    if (cur < TH_LOW || cur > TH_FAULT)           cand = Z_FAULT;
    else if (cur > TH_HIGH)                       cand = Z_HIGH;
    else if (committed == Z_HIGH && cur > TH_REL) cand = Z_HIGH;
    else                                          cand = Z_NORMAL;

    cnt_inc = (cand != pend_q[idx]) ? 1 : 32'(cnt_q[idx]) + 1;
    zone_n  = committed;
    pend_n  = Z_UNKNOWN;
    cnt_n   = '0;
    if (committed == Z_UNKNOWN) begin
      zone_n = cand;
    end else if (cand != committed) begin
      if (cnt_inc >= DEBOUNCE) begin
        zone_n = cand;
      end else begin
        pend_n = cand;
        cnt_n  = DB_W'(cnt_inc);
      end
    end
  end

  // Per-channel sample and classifier state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sample_q[i] <= '0;
        zone_q[i]   <= Z_UNKNOWN;
        pend_q[i]   <= Z_UNKNOWN;
        cnt_q[i]    <= '0;
      end
    end else begin
      if (latch_c) sample_q[idx] <= conv_data;
      if (eval_c) begin
        zone_q[idx] <= zone_n;
        pend_q[idx] <= pend_n;
        cnt_q[idx]  <= cnt_n;
      end else if (to_done) begin
        zone_q[idx] <= Z_UNKNOWN;
        pend_q[idx] <= Z_UNKNOWN;
        cnt_q[idx]  <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign zone[2*g +: 2]              = zone_q[g];
    assign samples[g*DATA_W +: DATA_W] = sample_q[g];
  end

  // LED view of the selected channel
  always_comb begin
    led_c = 3'b111;
    if (32'(sel) < NUM_CH) begin
      case (zone_q[sel])
        Z_FAULT:  led_c = 3'b110;
        Z_NORMAL: led_c = 3'b101;
        Z_HIGH:   led_c = 3'b011;
        default:  led_c = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_n <= 3'b111;
    else     led_n <= led_c;
  end

endmodule

// File: tb/tb_ads1115_scan_monitor.sv
// Directed bench for ads1115_scan_monitor: models the I2C engine answering each request 3 cycles later.
`timescale 1ns/1ps
module tb_ads1115_scan_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        conv_req;
  logic [1:0]  conv_ch;
  logic        conv_valid;
  logic [15:0] conv_data;
  logic [7:0]  zone;
  logic [63:0] samples;
  logic [3:0]  timeout_err;
  logic [2:0]  led_n;

  int checks = 0;
  int errors = 0;
  logic [15:0] feed [4];

  ads1115_scan_monitor #(.SCAN_GAP(8), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .sel(sel), .conv_req(conv_req), .conv_ch(conv_ch),
    .conv_valid(conv_valid), .conv_data(conv_data), .zone(zone), .samples(samples),
    .timeout_err(timeout_err), .led_n(led_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output logic ok);
    int n = 0;
    while (conv_req !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (conv_req === 1'b1);
    if (!ok) check("req_wait", 64'(conv_req), 64'd1);
  endtask

  task automatic serve(input logic [15:0] data, input logic [1:0] ch);
    logic ok;
    wait_req(ok);
    if (ok) begin
      check($sformatf("conv_ch_%0d", ch), 64'(conv_ch), 64'(ch));
      repeat (3) @(negedge clk);
      conv_valid = 1'b1;
      conv_data  = data;
      @(negedge clk);
      conv_valid = 1'b0;
      conv_data  = '0;
    end
  endtask

  task automatic round();
    for (int c = 0; c < 4; c++) serve(feed[c], 2'(c));
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] bvals [5] = '{16'h0F9F, 16'h0FA0, 16'h7D01, 16'h7D00, 16'h8000};
  logic [1:0]  bexp  [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [15:0] dseq  [5] = '{16'h6000, 16'h6000, 16'h3000, 16'h6000, 16'h6000};

  initial begin
    logic       ok;
    logic [1:0] prev;
    rst = 1'b1; sel = 2'd0; conv_valid = 1'b0; conv_data = '0;
    for (int c = 0; c < 4; c++) feed[c] = 16'h3000;
    repeat (2) @(negedge clk);
    check("rst_zone", 64'(zone), 64'hFF);
    check("rst_samples", samples, 64'd0);
    check("rst_led", 64'(led_n), 64'h7);
    check("rst_req", 64'(conv_req), 64'd0);
    check("rst_ch", 64'(conv_ch), 64'd0);
    check("rst_tmo", 64'(timeout_err), 64'd0);
    rst = 1'b0;

    // First results commit immediately from UNKNOWN
    round();
    check("first_zone", 64'(zone), 64'h55);
    check("first_samples", samples, 64'h3000_3000_3000_3000);
    check("first_led", 64'(led_n), 64'h5);

    // Strobe outside WAIT is ignored
    conv_valid = 1'b1; conv_data = 16'hFFFF;
    @(negedge clk);
    conv_valid = 1'b0; conv_data = '0;
    repeat (3) @(negedge clk);
    check("stray_samples", samples, 64'h3000_3000_3000_3000);
    check("stray_zone", 64'(zone), 64'h55);

    // Channel 1 NORMAL -> HIGH after three samples
    feed[1] = 16'h6000;
    round(); check("ch1_s1", 64'(zone[3:2]), 64'h1);
    round(); check("ch1_s2", 64'(zone[3:2]), 64'h1);
    round(); check("ch1_s3", 64'(zone[3:2]), 64'h2);
    sel = 2'd1;
    repeat (2) @(negedge clk);
    check("ch1_led", 64'(led_n), 64'h3);

    // Channel 2 hysteresis
    feed[2] = 16'h6000;
    repeat (3) round();
    check("ch2_high", 64'(zone[5:4]), 64'h2);
    feed[2] = 16'h57A0;
    repeat (3) round();
    check("ch2_hyst_hold", 64'(zone[5:4]), 64'h2);
    feed[2] = 16'h5700;
    repeat (2) round();
    check("ch2_rel_pend", 64'(zone[5:4]), 64'h2);
    round();
    check("ch2_rel", 64'(zone[5:4]), 64'h1);
    sel = 2'd2;
    repeat (2) @(negedge clk);
    check("ch2_led", 64'(led_n), 64'h5);

    // Channel 3 threshold boundaries
    prev = 2'b01;
    for (int k = 0; k < 5; k++) begin
      feed[3] = bvals[k];
      repeat (2) round();
      check($sformatf("bnd_hold_%0h", bvals[k]), 64'(zone[7:6]), 64'(prev));
      round();
      check($sformatf("bnd_%0h", bvals[k]), 64'(zone[7:6]), 64'(bexp[k]));
      prev = bexp[k];
    end
    sel = 2'd3;
    repeat (2) @(negedge clk);
    check("ch3_led", 64'(led_n), 64'h6);
    check("ch3_sample", 64'(samples[63:48]), 64'h8000);

    // Channel 0 debounce interrupted by an agreeing sample
    for (int k = 0; k < 5; k++) begin
      feed[0] = dseq[k];
      round();
    end
    check("db_interrupt", 64'(zone[1:0]), 64'h1);
    feed[0] = 16'h6000;
    round();
    check("db_commit", 64'(zone[1:0]), 64'h2);
    sel = 2'd0;
    repeat (2) @(negedge clk);
    check("ch0_led", 64'(led_n), 64'h3);

`ifdef ADS_SCAN_TIMEOUT_EN
    // Channel 3 left unanswered
    for (int c = 0; c < 3; c++) serve(feed[c], 2'(c));
    wait_req(ok);
    check("tmo_ch", 64'(conv_ch), 64'd3);
    repeat (50) @(negedge clk);
    check("tmo_early", 64'(timeout_err), 64'd0);
    @(negedge clk);
    check("tmo_err", 64'(timeout_err), 64'h8);
    check("tmo_zone", 64'(zone[7:6]), 64'h3);
    check("tmo_sample", 64'(samples[63:48]), 64'h8000);
`endif

    // Reset while waiting on channel 1
    serve(feed[0], 2'd0);
    wait_req(ok);
    check("pre_rst_ch", 64'(conv_ch), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_zone", 64'(zone), 64'hFF);
    check("arst_samples", samples, 64'd0);
    check("arst_led", 64'(led_n), 64'h7);
    check("arst_req", 64'(conv_req), 64'd0);
    check("arst_ch", 64'(conv_ch), 64'd0);
    check("arst_tmo", 64'(timeout_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) feed[c] = 16'h3000;
    round();
    check("post_rst_zone", 64'(zone), 64'h55);
    check("post_rst_samples", samples, 64'h3000_3000_3000_3000);
    check("post_rst_tmo", 64'(timeout_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
